// File: rtl/dec_2of5_serial_pkg.sv
// Shared definitions for the 2-out-of-5 digit code: code table, error digit,
// word width, receiver state type and a weight helper.
package dec_2of5_serial_pkg;

    localparam int WORD_W  = 5;
    localparam int DIGIT_W = 4;

    // Code words, written as code[4:0]; exactly two ones each.
    localparam logic [WORD_W-1:0] CODE_0 = 5'b11000;
    localparam logic [WORD_W-1:0] CODE_1 = 5'b00011;
    localparam logic [WORD_W-1:0] CODE_2 = 5'b00101;
    localparam logic [WORD_W-1:0] CODE_3 = 5'b00110;
    localparam logic [WORD_W-1:0] CODE_4 = 5'b01001;
    localparam logic [WORD_W-1:0] CODE_5 = 5'b01010;
    localparam logic [WORD_W-1:0] CODE_6 = 5'b01100;
    localparam logic [WORD_W-1:0] CODE_7 = 5'b10001;
    localparam logic [WORD_W-1:0] CODE_8 = 5'b10010;
    localparam logic [WORD_W-1:0] CODE_9 = 5'b10100;

    localparam logic [DIGIT_W-1:0] DIGIT_ERR = 4'hF;

    // IDLE: no bits of a word held; COLLECT: 1..4 bits held.
    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_e;

    // Number of ones in a code word.
    function automatic logic [2:0] code_weight(input logic [WORD_W-1:0] code);
        logic [2:0] w;
        w = 3'd0;
        for (int i = 0; i < WORD_W; i++) begin
            w = w + {2'b00, code[i]};
        end
        return w;
    endfunction

endpackage

// File: rtl/dec_2of5_serial_if.sv
// Serial input and result output bundle of the 2-of-5 receiver.
// master: the side feeding bits and consuming results; slave: the receiver.
interface dec_2of5_serial_if
    import dec_2of5_serial_pkg::*;
#(
    parameter int ERR_CNT_W = 8
);
    logic                 sin;
    logic                 sin_valid;
    logic                 sof;
    logic                 sin_ready;
    logic [DIGIT_W-1:0]   digit;
    logic                 code_err;
    logic                 out_valid;
    logic                 out_ready;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output sin, sin_valid, sof, out_ready,
        input  sin_ready, digit, code_err, out_valid, err_cnt
    );

    modport slave (
        input  sin, sin_valid, sof, out_ready,
        output sin_ready, digit, code_err, out_valid, err_cnt
    );
endinterface

// File: rtl/dec_2of5_serial_lookup.sv
// Combinational 2-of-5 word to BCD digit lookup. Any word whose weight is not
// two flags err and returns DIGIT_ERR. Reusable by a parallel decoder.
module dec_2of5_lookup
    import dec_2of5_serial_pkg::*;
(
    input  logic [WORD_W-1:0]  code_i,
    output logic [DIGIT_W-1:0] digit_o,
    output logic               err_o
);

    // Weight check first; the table covers all ten weight-2 patterns.
    always_comb begin
        err_o   = (code_weight(code_i) != 3'd2);
        digit_o = DIGIT_ERR;
        if (!err_o) begin
            case (code_i)
                CODE_0:  digit_o = 4'd0;
                CODE_1:  digit_o = 4'd1;
                CODE_2:  digit_o = 4'd2;
                CODE_3:  digit_o = 4'd3;
                CODE_4:  digit_o = 4'd4;
                CODE_5:  digit_o = 4'd5;
                CODE_6:  digit_o = 4'd6;
                CODE_7:  digit_o = 4'd7;
                CODE_8:  digit_o = 4'd8;
                CODE_9:  digit_o = 4'd9;
                default: digit_o = DIGIT_ERR;
            endcase
        end
    end

endmodule

// File: rtl/dec_2of5_serial.sv
// Serial 2-of-5 receiver: assembles 5-bit words one bit per cycle, decodes
// them to BCD, presents results on a valid/ready register and counts
// invalid words with a saturating counter.
module dec_2of5_serial
    import dec_2of5_serial_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1,
    parameter int ERR_CNT_W = 8
) (
    input logic               clk,
    input logic               rst_n,
    dec_2of5_serial_if.slave  bus
);

    state_e               state_q, state_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]    shreg_q, shreg_d;
    logic [DIGIT_W-1:0]   digit_q, digit_d;
    logic                 code_err_q, code_err_d;
    logic                 out_valid_q, out_valid_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic                 sin_rdy;
    logic                 accept;
    logic                 complete;
    logic                 new_word;
    logic [2:0]           slot;
    logic [2:0]           pos;
    logic [WORD_W-1:0]    word_asm;
    logic [DIGIT_W-1:0]   lk_digit;
    logic                 lk_err;

    // Handshake and word assembly: the current bit merged into the held bits.
    // A sof bit (or the first bit after a completed word) starts from zero.
    always_comb begin
        sin_rdy  = !((bit_cnt_q == 3'd4) && out_valid_q && !bus.out_ready);
        accept   = bus.sin_valid && sin_rdy;
        new_word = bus.sof || (state_q == IDLE);
        slot     = bus.sof ? 3'd0 : bit_cnt_q;
        pos      = MSB_FIRST ? (3'd4 - slot) : slot;
        word_asm = new_word ? '0 : shreg_q;
        word_asm[pos] = bus.sin;
        // sof on the 5th position restarts instead of completing
        complete = accept && !bus.sof && (bit_cnt_q == 3'd4);
    end

    dec_2of5_lookup u_lookup (
        .code_i  (word_asm),
        .digit_o (lk_digit),
        .err_o   (lk_err)
    );

    // Next state of the bit counter FSM and shift register; moves only on an accepted bit.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        if (accept) begin
            if (bus.sof) begin
                state_d   = COLLECT;
                bit_cnt_d = 3'd1;
                shreg_d   = word_asm;
            end else if (bit_cnt_q == 3'd4) begin
                state_d   = IDLE;
                bit_cnt_d = 3'd0;
                shreg_d   = '0;
            end else begin
                state_d   = COLLECT;
                bit_cnt_d = bit_cnt_q + 3'd1;
                shreg_d   = word_asm;
            end
        end
    end

    // Next state of the output register and saturating error counter.
    // Completion can only happen when the register is free or draining.
    always_comb begin
        digit_d     = digit_q;
        code_err_d  = code_err_q;
        out_valid_d = out_valid_q;
        err_cnt_d   = err_cnt_q;
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (complete) begin
            digit_d     = lk_digit;
            code_err_d  = lk_err;
            out_valid_d = 1'b1;
            if (lk_err && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Word assembly FSM registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            shreg_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
        end
    end

    // Output result register and error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q     <= '0;
            code_err_q  <= 1'b0;
            out_valid_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            digit_q     <= digit_d;
            code_err_q  <= code_err_d;
            out_valid_q <= out_valid_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.sin_ready = sin_rdy;
    assign bus.digit     = digit_q;
    assign bus.code_err  = code_err_q;
    assign bus.out_valid = out_valid_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_dec_2of5_serial.sv
// Bench for dec_2of5_serial: three instances (MSB-first 8-bit counter,
// LSB-first 8-bit counter, MSB-first 2-bit counter) share one input stream
// and are compared every cycle against a word-level reference model.
module tb_dec_2of5_serial;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic sin_t, vld_t, sof_t, ordy_t;

    dec_2of5_serial_if #(.ERR_CNT_W(8)) bus_m ();
    dec_2of5_serial_if #(.ERR_CNT_W(8)) bus_l ();
    dec_2of5_serial_if #(.ERR_CNT_W(2)) bus_s ();

    assign bus_m.sin = sin_t;  assign bus_m.sin_valid = vld_t;
    assign bus_m.sof = sof_t;  assign bus_m.out_ready = ordy_t;
    assign bus_l.sin = sin_t;  assign bus_l.sin_valid = vld_t;
    assign bus_l.sof = sof_t;  assign bus_l.out_ready = ordy_t;
    assign bus_s.sin = sin_t;  assign bus_s.sin_valid = vld_t;
    assign bus_s.sof = sof_t;  assign bus_s.out_ready = ordy_t;

    dec_2of5_serial #(.MSB_FIRST(1'b1), .ERR_CNT_W(8)) dut_m (.clk(clk), .rst_n(rst_n), .bus(bus_m));
    dec_2of5_serial #(.MSB_FIRST(1'b0), .ERR_CNT_W(8)) dut_l (.clk(clk), .rst_n(rst_n), .bus(bus_l));
    dec_2of5_serial #(.MSB_FIRST(1'b1), .ERR_CNT_W(2)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

    // Reference code table, code[4:0] indexed by digit
    logic [4:0] ref_codes [10] = '{5'b11000, 5'b00011, 5'b00101, 5'b00110, 5'b01001,
                                   5'b01010, 5'b01100, 5'b10001, 5'b10010, 5'b10100};

    int tests  = 0;
    int failed = 0;

    // Reference model state
    bit         word_q[$];
    logic       m_valid;
    logic [3:0] m_dig_msb, m_dig_lsb;
    logic       m_err;
    int         m_errs;

    function automatic void ref_decode(input logic [4:0] c, output logic [3:0] d, output logic e);
        e = ($countones(c) != 2);
        d = 4'hF;
        if (!e) begin
            for (int i = 0; i < 10; i++) begin
                if (ref_codes[i] == c) d = 4'(i);
            end
        end
    endfunction

    function automatic logic exp_ready();
        return !((word_q.size() == 4) && m_valid && !ordy_t);
    endfunction

    task automatic model_reset();
        word_q.delete();
        m_valid   = 1'b0;
        m_dig_msb = 4'd0;
        m_dig_lsb = 4'd0;
        m_err     = 1'b0;
        m_errs    = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("m_out_valid", bus_m.out_valid, m_valid);
        check("l_out_valid", bus_l.out_valid, m_valid);
        check("s_out_valid", bus_s.out_valid, m_valid);
        check("m_digit", bus_m.digit, m_dig_msb);
        check("l_digit", bus_l.digit, m_dig_lsb);
        check("s_digit", bus_s.digit, m_dig_msb);
        check("m_code_err", bus_m.code_err, m_err);
        check("l_code_err", bus_l.code_err, m_err);
        check("s_code_err", bus_s.code_err, m_err);
        check("m_err_cnt", bus_m.err_cnt, (m_errs > 255) ? 255 : m_errs);
        check("l_err_cnt", bus_l.err_cnt, (m_errs > 255) ? 255 : m_errs);
        check("s_err_cnt", bus_s.err_cnt, (m_errs > 3) ? 3 : m_errs);
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle(input logic v, input logic b, input logic s, output logic acc);
        logic er, xfer;
        logic [4:0] c_msb, c_lsb;
        logic [3:0] d_tmp;
        logic e_tmp;
        vld_t = v; sin_t = b; sof_t = s;
        #1;
        er = exp_ready();
        check("m_sin_ready", bus_m.sin_ready, er);
        check("l_sin_ready", bus_l.sin_ready, er);
        check("s_sin_ready", bus_s.sin_ready, er);
        acc  = v && er;
        xfer = m_valid && ordy_t;
        @(posedge clk);
        if (xfer) m_valid = 1'b0;
        if (acc) begin
            if (s) word_q.delete();
            word_q.push_back(b);
            if (!s && word_q.size() == 5) begin
                for (int i = 0; i < 5; i++) begin
                    c_msb[4-i] = word_q[i];
                    c_lsb[i]   = word_q[i];
                end
                ref_decode(c_msb, m_dig_msb, m_err);
                ref_decode(c_lsb, d_tmp, e_tmp);
                m_dig_lsb = d_tmp;
                m_valid = 1'b1;
                if (m_err) m_errs++;
                word_q.delete();
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send_bit(input logic b, input logic s);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 20) begin
            cycle(1'b1, b, s, acc);
            n++;
        end
        check("send_timeout", acc, 1'b1);
    endtask

    // Transmit code[4:0] with code[4] first, sof on the first bit.
    task automatic send_word(input logic [4:0] c);
        for (int i = 4; i >= 0; i--) send_bit(c[i], i == 4);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc);
    endtask

    function automatic logic [4:0] rand_invalid();
        logic [4:0] c;
        c = 5'($urandom_range(0, 31));
        while ($countones(c) == 2) c = 5'($urandom_range(0, 31));
        return c;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic acc;
        int   saved_errs;
        int   sat_exp [5] = '{1, 2, 3, 3, 3};

        rst_n = 1'b0; vld_t = 1'b0; sin_t = 1'b0; sof_t = 1'b0; ordy_t = 1'b1;
        model_reset();
        @(negedge clk);
        check_outputs();
        check("reset_sin_ready", bus_m.sin_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single word 01010 -> 5
        send_word(5'b01010);
        check("t1_digit", bus_m.digit, 4'd5);
        check("t1_valid", bus_m.out_valid, 1'b1);
        idle(1);
        check("t1_valid_drop", bus_m.out_valid, 1'b0);

        // All ten codes back to back
        for (int d = 0; d < 10; d++) begin
            send_word(ref_codes[d]);
            check("stream_digit", bus_m.digit, d);
        end
        idle(1);

        // Invalid words
        send_word(5'b11100);
        check("err1_digit", bus_m.digit, 4'hF);
        check("err1_flag", bus_m.code_err, 1'b1);
        check("err1_cnt", bus_m.err_cnt, 1);
        send_word(5'b00000);
        check("err2_cnt", bus_m.err_cnt, 2);
        idle(1);

        // Backpressure: result 7 held, then 01100 stalls on its 5th bit
        ordy_t = 1'b0;
        send_word(ref_codes[7]);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, acc);
        cycle(1'b1, 1'b0, 1'b0, acc);
        check("stall_ready", bus_m.sin_ready, 1'b0);
        check("stall_digit", bus_m.digit, 4'd7);
        ordy_t = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, acc);
        check("release_digit", bus_m.digit, 4'd6);
        check("release_valid", bus_m.out_valid, 1'b1);
        idle(1);

        // Partial word discarded by sof
        saved_errs = m_errs;
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_word(ref_codes[1]);
        check("partial_digit", bus_m.digit, 4'd1);
        check("partial_errcnt", bus_m.err_cnt, saved_errs);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            ordy_t = 1'($urandom_range(0, 3) != 0);
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 7) == 0), acc);
        end

        // Asynchronous reset mid-word with a pending result
        ordy_t = 1'b0;
        send_word(ref_codes[3]);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check("async_sin_ready", bus_m.sin_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        ordy_t = 1'b1;

        // Saturation of the 2-bit counter
        for (int k = 0; k < 5; k++) begin
            send_word(rand_invalid());
            check("sat_cnt", bus_s.err_cnt, sat_exp[k]);
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/dec_2of5_serial.md
# dec_2of5_serial

Serial receiver and decoder for the 2-out-of-5 digit code produced by the team's BCD-to-2-of-5 encoder. It deserialises 5-bit code words presented one bit per cycle and decodes each word back to a BCD digit. Each word is also checked for exactly two ones. Results go to a downstream consumer over a valid/ready output register, and a saturating error counter is maintained. The block sits at the receive end of the digit link, after bit capture and before BCD digit consumers.

## Interface
- MSB_FIRST, 1, 1: first received bit is code bit 4; 0: first received bit is code bit 0
- ERR_CNT_W, 8, width of the saturating invalid-word counter
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- sin  input  1  serial code bit
- sin_valid  input  1  sin carries a bit this cycle
- sof  input  1  start of word, qualified by sin_valid; this bit is the first bit of a new word
- sin_ready  output  1  block accepts a bit this cycle; a bit transfers when sin_valid && sin_ready
- digit  output  4  decoded BCD digit, 0..9
- code_err  output  1  word did not contain exactly two ones; digit = 4'hF
- out_valid  output  1  digit/code_err hold a result
- out_ready  input  1  consumer accepts; a result transfers when out_valid && out_ready
- err_cnt  output  ERR_CNT_W  count of invalid words, saturates at all-ones

## Operation
- Code map (code[4:0] -> digit):
  - 11000->0, 00011->1, 00101->2, 00110->3, 01001->4
  - 01010->5, 01100->6, 10001->7, 10010->8, 10100->9
- Every weight-2 pattern is valid. Any other weight (0, 1, 3, 4, 5) gives code_err=1 and digit=4'hF.
- Word assembly uses a 5-bit shift register and a bit counter, bit_cnt 0..4.
  - Each accepted bit stores into the position selected by MSB_FIRST and bit_cnt, then increments bit_cnt.
  - The 5th accepted bit (bit_cnt==4) completes the word. bit_cnt returns to 0.
- sof resync: an accepted bit with sof=1 discards any partial word, is stored as bit 0 of a new word, and sets bit_cnt=1. The discarded partial is not counted as an error.
- A completed word is decoded combinationally from the assembled value and loaded into the output register. out_valid is set.
- Output register:
  - It holds its value until a transfer occurs.
  - A transfer in the same cycle as a new completion loads the new result; out_valid stays 1.
- err_cnt increments once per completed word with code_err=1. It saturates and never wraps.
- Backpressure: sin_ready = !(bit_cnt==4 && out_valid && !out_ready). Bits 1..4 of the next word are always accepted while a result waits.
- State machine over bit_cnt: IDLE (0), COLLECT (1..4). Transitions occur only on an accepted bit.

## Timing
- Reset values:
  - digit=0, code_err=0, out_valid=0, err_cnt=0
  - bit_cnt=0, shift register=0
  - sin_ready=1
- Latency: the result is visible, with out_valid=1, the cycle after the edge that accepts the 5th bit.
- Throughput: one word per 5 accepted bits, with no bubbles when out_ready=1.
- Simultaneous sof on a 5th-bit position: sof wins. No word completes, and the bit starts a new word.
- Reset asserted mid-word or with a pending result: all state clears immediately. The partial word and pending result are lost.
- sin, sof and out_ready are ignored when their qualifiers are low.

## Structure
- The shared package holds:
  - the 10-entry code table as localparams (CODE_0..CODE_9)
  - the constant DIGIT_ERR = 4'hF
  - the constant WORD_W = 5
- The encoder and this decoder both use the same code table constants.
- Sub-module dec_2of5_lookup is combinational. It takes code[4:0] and produces digit[3:0] and err; it is reusable by a parallel decoder.
- The top level holds the shift register, bit counter, output register and error counter.

## Test plan
- MSB_FIRST=1, send bits 0,1,0,1,0 (sof on the first), out_ready=1 -> one cycle after the 5th bit: digit=5, code_err=0, out_valid=1 for 1 cycle; err_cnt=0.
- Stream all ten codes 0..9 back-to-back, out_ready=1 -> digits 0..9 in order, one result every 5 cycles, no sin_ready drop.
- Send 11100 -> digit=4'hF, code_err=1, err_cnt=1. Then send 00000 -> err_cnt=2.
- Hold out_ready=0 after the result for 7, then stream 01100:
  - 4 bits are accepted, then sin_ready=0 on the 5th bit
  - raise out_ready: 7 transfers, the next cycle's accepted bit completes, then digit=6 is presented
- Send 3 bits of 10010, then sof with 00011 -> partial discarded, digit=1, err_cnt unchanged. Assert rst_n=0 mid-word -> all outputs return to reset values asynchronously.
- ERR_CNT_W=2, send 5 invalid words -> err_cnt reads 1, 2, 3, 3, 3.
